// File: rtl/bus_arbiter.sv
// Round-robin request arbiter for the coherence bus controller.
// Picks one L1 requester, classifies its request, and holds the grant,
// type and address stable until the controller finishes or the requester
// aborts before the transaction has started.
module bus_arbiter #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS-1:0]          ccwrite,
  input  logic [CPUS-1:0]          ccabort,
  input  logic [CPUS*ADDR_W-1:0]   daddr,
  input  logic                     bus_busy,
  input  logic                     txn_done,
  output logic                     grant_valid,
  output logic [CPUS-1:0]          grant,
  output logic [$clog2(CPUS)-1:0]  grant_idx,
  output logic [1:0]               grant_type,
  output logic [ADDR_W-1:0]        grant_addr
);

  localparam int IDX_W = $clog2(CPUS);

  typedef enum logic {IDLE, GRANTED} state_t;

  typedef enum logic [1:0] {
    GT_R     = 2'd0,
    GT_RX    = 2'd1,
    GT_EVICT = 2'd2,
    GT_INV   = 2'd3
  } gtype_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [CPUS-1:0]    req;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  gtype_t             win_type;
  logic [ADDR_W-1:0]  win_addr;
  logic               release_grant;
  logic [IDX_W-1:0]   ptr_after;

  assign req = dREN | dWEN | ccwrite;

  // Round-robin search: first set request at or above ptr, wrapping mod CPUS.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    // Walk offsets from far to near so the nearest hit is written last and wins.
    for (int k = CPUS - 1; k >= 0; k--) begin
      int cand;
      cand = int'(ptr) + k;
      if (cand >= CPUS) cand = cand - CPUS;
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Classify the winner's request; eviction outranks read-exclusive outranks read.
  always_comb begin
    win_type = GT_INV;
    if (dWEN[win_idx])                         win_type = GT_EVICT;
    else if (dREN[win_idx] && ccwrite[win_idx]) win_type = GT_RX;
    else if (dREN[win_idx])                    win_type = GT_R;
    win_addr = daddr[int'(win_idx)*ADDR_W +: ADDR_W];
  end

  // An abort only counts before the controller has left its GRANT_* state.
  assign release_grant = txn_done | (ccabort[grant_idx] & ~bus_busy);
  assign ptr_after     = (grant_idx == IDX_W'(CPUS - 1)) ? '0 : grant_idx + 1'b1;

  // Arbitration FSM with registered grant outputs and the priority pointer.
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values and evaluation order inside the block cannot matter.
    if (RST) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_valid <= 1'b0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_type  <= GT_R;
      grant_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state       <= GRANTED;
            grant_valid <= 1'b1;
            grant       <= CPUS'(1) << win_idx;
            grant_idx   <= win_idx;
            grant_type  <= win_type;
            grant_addr  <= win_addr;
          end
        end
        GRANTED: begin
          if (release_grant) begin
            state       <= IDLE;
            ptr         <= ptr_after;
            grant_valid <= 1'b0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_type  <= GT_R;
            grant_addr  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin request arbiter in front of the coherence bus controller.
- Watches every L1 front-side request (dREN, dWEN, ccwrite) across CPUS caches and picks exactly one requester.
- Classifies the winning request into a grant type and holds the grant, latched type and latched address stable until the bus controller signals completion.
- The bus controller's FSM consumes the grant to enter its GRANT_R / GRANT_RX / GRANT_EVICT / GRANT_INV states.

Parameters:
- CPUS, 2, number of L1 requesters (NUM_HARTS*2 in system); must be >= 2.
- ADDR_W, 32, request address width.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- dREN  input  CPUS  per-requester read request.
- dWEN  input  CPUS  per-requester writeback (evict) request.
- ccwrite  input  CPUS  requester intends to reach M.
- ccabort  input  CPUS  requester withdraws its pending request.
- daddr  input  CPUS*ADDR_W  per-requester address, packed, requester i at bits [i*ADDR_W +: ADDR_W].
- bus_busy  input  1  controller has started the granted transaction (left its GRANT_* state).
- txn_done  input  1  one-cycle pulse: controller finished the granted transaction.
- grant_valid  output  1  a grant is held.
- grant  output  CPUS  one-hot grant vector; all zero when grant_valid=0.
- grant_idx  output  $clog2(CPUS)  index of the granted requester.
- grant_type  output  2  0=R, 1=RX, 2=EVICT, 3=INV.
- grant_addr  output  ADDR_W  daddr of the granted requester, latched at grant.

Behaviour:
- Reset (RST=1 at a clock edge):
  - State -> IDLE; priority pointer -> 0.
  - grant_valid=0, grant=0, grant_idx=0, grant_type=0, grant_addr=0.
  - Reset mid-grant drops the grant the same edge; no txn_done is needed.
- Request vector: req[i] = dREN[i] | dWEN[i] | ccwrite[i].
- Classification, evaluated in this priority order:
  - dWEN -> EVICT.
  - dREN & ccwrite -> RX.
  - dREN -> R.
  - ccwrite alone -> INV.
- FSM states: IDLE, GRANTED.
- IDLE:
  - If req != 0, select the first set bit of req searching from pointer upward with wrap modulo CPUS.
  - Next edge: go to GRANTED; register grant, grant_idx, grant_type and grant_addr from the winner's current inputs.
  - Grant latency is 1 cycle from request visibility.
  - If req == 0, stay in IDLE.
- GRANTED:
  - All grant outputs are held constant regardless of input changes.
  - If txn_done=1: next edge -> IDLE, outputs cleared, pointer <- (grant_idx+1) mod CPUS.
  - Else if ccabort[grant_idx]=1 and bus_busy=0: same release as txn_done, including the pointer advance.
  - Else if ccabort[grant_idx]=1 and bus_busy=1: the abort is ignored; the grant holds until txn_done.
  - If txn_done and ccabort arrive in the same cycle, treat it as txn_done (identical effect).
- Re-arbitration:
  - At least one IDLE cycle separates consecutive grants.
  - Earliest next grant_valid is 2 edges after the txn_done cycle.
- Fairness: a requester holding req continuously is granted within CPUS grants.
- Requests arriving during GRANTED are not lost: req is level-sampled in IDLE.
- txn_done while in IDLE is ignored.
- The pointer never changes except on release or reset.
- Invariant: grant_valid=1 implies grant is one-hot with grant[grant_idx]=1; grant_valid=0 implies grant=0.

Test Plan:
- Reset, then CPUS=2, dREN[0]=1 with daddr[0]=0x100 -> one cycle later grant_valid=1, grant=2'b01, grant_type=R, grant_addr=0x100. After txn_done pulse -> grant_valid=0 the next cycle.
- dREN[0]=dREN[1]=1 held continuously, txn_done pulsed 3 cycles after each grant -> grants alternate 0,1,0,1 with one idle cycle between them.
- dWEN[1]=1 and dREN[1]=1 together -> grant_type=EVICT. Separately, ccwrite[0]=1 alone -> INV. dREN[0]&ccwrite[0] -> RX.
- Grant to 0 with bus_busy=0, then ccabort[0]=1 -> released next cycle and pointer=1. Repeat with bus_busy=1 -> grant held until txn_done.
- While granted to 0, change daddr[0] to 0x200 and assert dREN[1] -> grant_addr stays 0x100 and grant stays 2'b01. After txn_done, requester 1 is granted.
- Assert RST while GRANTED -> all outputs 0 the next edge and pointer=0. With txn_done and ccabort simultaneous -> a single release.
